// File: rtl/seq_mul.sv
// Multi-cycle shift-add multiplier: one PART_DATA_WIDTH slice of operand B per cycle.
// Optional two's-complement operands when MUL_SIGNED_EN is defined.
module seq_mul #(
   parameter int DATA_WIDTH      = 32,
   parameter int RES_WIDTH       = 64,
   parameter int PART_DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data_1,
   input  logic [DATA_WIDTH-1:0] wr_data_2,
   output logic [RES_WIDTH-1:0]  rd_data,
   output logic                  wr_ready,
   output logic                  rd_ready,
   output logic                  rd_val
);

   localparam int N     = DATA_WIDTH / PART_DATA_WIDTH;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [RES_WIDTH-1:0]   a_shift_reg, a_shift_next;
   logic [DATA_WIDTH-1:0]  b_shift_reg, b_shift_next;
   logic [RES_WIDTH-1:0]   acc_reg, acc_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [RES_WIDTH-1:0]   rd_data_reg, rd_data_next;
   logic                   rd_val_reg, rd_val_next;
   logic [DATA_WIDTH-1:0]  a_mag, b_mag;
   logic [RES_WIDTH-1:0]   partial, sum, final_res;
`ifdef MUL_SIGNED_EN
   logic                   sign_reg, sign_next;
`endif

   // A is kept pre-shifted to the current slice weight, so the partial
   // product equals (A * slice) << (counter*P) without a variable shifter.
   assign partial = a_shift_reg * RES_WIDTH'(b_shift_reg[PART_DATA_WIDTH-1:0]);
   assign sum     = acc_reg + partial;

`ifdef MUL_SIGNED_EN
   assign a_mag     = wr_data_1[DATA_WIDTH-1] ? -wr_data_1 : wr_data_1;
   assign b_mag     = wr_data_2[DATA_WIDTH-1] ? -wr_data_2 : wr_data_2;
   assign final_res = sign_reg ? -sum : sum;
`else
   assign a_mag     = wr_data_1;
   assign b_mag     = wr_data_2;
   assign final_res = sum;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         a_shift_reg <= '0;
         b_shift_reg <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         rd_data_reg <= '0;
         rd_val_reg  <= 1'b0;
`ifdef MUL_SIGNED_EN
         sign_reg    <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         a_shift_reg <= a_shift_next;
         b_shift_reg <= b_shift_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         rd_data_reg <= rd_data_next;
         rd_val_reg  <= rd_val_next;
`ifdef MUL_SIGNED_EN
         sign_reg    <= sign_next;
`endif
      end
   end

   always_comb begin
      state_next   = state_reg;
      a_shift_next = a_shift_reg;
      b_shift_next = b_shift_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      rd_data_next = rd_data_reg;
      rd_val_next  = 1'b0;
`ifdef MUL_SIGNED_EN
      sign_next    = sign_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (wr_en) begin
               a_shift_next = RES_WIDTH'(a_mag);
               b_shift_next = b_mag;
               acc_next     = '0;
               cnt_next     = '0;
`ifdef MUL_SIGNED_EN
               sign_next    = wr_data_1[DATA_WIDTH-1] ^ wr_data_2[DATA_WIDTH-1];
`endif
               state_next   = CALC;
            end
         end
         CALC: begin
            acc_next     = sum;
            a_shift_next = a_shift_reg << PART_DATA_WIDTH;
            b_shift_next = b_shift_reg >> PART_DATA_WIDTH;
            cnt_next     = cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               rd_data_next = final_res;
               rd_val_next  = 1'b1;
               state_next   = DONE;
            end
         end
         DONE: begin
            if (rd_en) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign rd_data  = rd_data_reg;
   assign rd_val   = rd_val_reg;
   assign wr_ready = (state_reg == IDLE);
   assign rd_ready = (state_reg == DONE);

endmodule

// File: tb/tb_seq_mul.sv
// Randomized self-checking bench for seq_mul against an arithmetic product model.
// Honours MUL_SIGNED_EN the same way as the design.
module tb_seq_mul;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data_1 = '0;
   logic [31:0] wr_data_2 = '0;
   logic [63:0] rd_data;
   logic        wr_ready, rd_ready, rd_val;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [63:0] last_res = '0;

   seq_mul #(.DATA_WIDTH(32), .RES_WIDTH(64), .PART_DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .wr_en(wr_en),
      .wr_data_1(wr_data_1), .wr_data_2(wr_data_2),
      .rd_data(rd_data), .wr_ready(wr_ready), .rd_ready(rd_ready), .rd_val(rd_val)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_SIGNED_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
`else
      return {32'b0, a} * {32'b0, b};
`endif
   endfunction

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue an operation at a negedge; returns at the negedge after the accept edge.
   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      check_val("wr_ready_before_start", 64'(wr_ready), 64'd1);
      wr_en = 1'b1; wr_data_1 = a; wr_data_2 = b;
      cycle();
      wr_en = 1'b0;
   endtask

   // Follow the calculation; optionally keep hammering wr_en with 2*3 meanwhile.
   task automatic finish_op(input logic [63:0] exp, input bit noise);
      for (int i = 1; i <= N; i++) begin
         if (noise) begin
            wr_en = 1'b1; wr_data_1 = 32'd2; wr_data_2 = 32'd3;
         end
         cycle();
         if (i < N) begin
            check_val("calc_rd_ready", 64'(rd_ready), 64'd0);
            check_val("calc_wr_ready", 64'(wr_ready), 64'd0);
            check_val("calc_rd_data_stable", rd_data, last_res);
         end else begin
            check_val("done_rd_ready", 64'(rd_ready), 64'd1);
            check_val("done_rd_val", 64'(rd_val), 64'd1);
            check_val("done_rd_data", rd_data, exp);
         end
      end
      cycle();
      check_val("strobe_one_cycle", 64'(rd_val), 64'd0);
      check_val("done_hold_ready", 64'(rd_ready), 64'd1);
      check_val("done_wr_ready", 64'(wr_ready), 64'd0);
      check_val("done_hold_data", rd_data, exp);
      wr_en = 1'b0;
      last_res = exp;
   endtask

   task automatic read_op();
      rd_en = 1'b1;
      cycle();
      rd_en = 1'b0;
      check_val("read_rd_ready", 64'(rd_ready), 64'd0);
      check_val("read_wr_ready", 64'(wr_ready), 64'd1);
      check_val("read_rd_data_kept", rd_data, last_res);
   endtask

   task automatic full_op(input logic [31:0] a, input logic [31:0] b, input bit noise);
      logic [63:0] exp;
      exp = model(a, b);
      start_op(a, b);
      finish_op(exp, noise);
      $display("op 0x%08h * 0x%08h -> 0x%016h (expect 0x%016h)", a, b, rd_data, exp);
      read_op();
   endtask

   initial begin
      logic [31:0] ra, rb;
      int          dly;

      // Reset held for two cycles
      reset = 1'b0;
      cycle(); cycle();
      check_val("reset_rd_data", rd_data, 64'd0);
      check_val("reset_wr_ready", 64'(wr_ready), 64'd1);
      check_val("reset_rd_ready", 64'(rd_ready), 64'd0);
      check_val("reset_rd_val", 64'(rd_val), 64'd0);
      reset = 1'b1;
      cycle();
      check_val("idle_wr_ready", 64'(wr_ready), 64'd1);

      // Basic product plus long hold without rd_en
      start_op(32'h00123456, 32'h00123456);
      finish_op(model(32'h00123456, 32'h00123456), 1'b0);
      check_val("basic_const", rd_data, 64'h0000014B66CB0CE4);
      for (int i = 0; i < 200; i++) begin
         cycle();
         if (rd_ready !== 1'b1 || rd_data !== 64'h0000014B66CB0CE4) begin
            check_val("hold_rd_ready", 64'(rd_ready), 64'd1);
            check_val("hold_rd_data", rd_data, 64'h0000014B66CB0CE4);
         end
      end
      check_val("hold_end_rd_ready", 64'(rd_ready), 64'd1);
      check_val("hold_end_rd_data", rd_data, 64'h0000014B66CB0CE4);
      $display("op 0x00123456 * 0x00123456 held 200 cycles -> 0x%016h", rd_data);
      read_op();

      // Max operands
      full_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
`ifndef MUL_SIGNED_EN
      check_val("max_const", rd_data, 64'hFFFFFFFE00000001);
`else
      check_val("max_signed_const", rd_data, 64'd1);
`endif

      // Ignored writes during CALC and DONE, ignored reads in IDLE
      full_op(32'h0000BEEF, 32'h00C0FFEE, 1'b1);
      rd_en = 1'b1;
      cycle(); cycle();
      rd_en = 1'b0;
      check_val("idle_rd_en_wr_ready", 64'(wr_ready), 64'd1);
      check_val("idle_rd_en_rd_ready", 64'(rd_ready), 64'd0);
      check_val("idle_rd_en_rd_val", 64'(rd_val), 64'd0);
      check_val("idle_rd_en_data", rd_data, last_res);
      $display("rd_en in IDLE -> wr_ready=%0b rd_ready=%0b", wr_ready, rd_ready);

      // Asynchronous reset in the middle of a calculation
      start_op(32'd5, 32'd7);
      cycle(); cycle();
      reset = 1'b0;
      #1;
      check_val("midreset_rd_data", rd_data, 64'd0);
      check_val("midreset_wr_ready", 64'(wr_ready), 64'd1);
      check_val("midreset_rd_ready", 64'(rd_ready), 64'd0);
      check_val("midreset_rd_val", 64'(rd_val), 64'd0);
      $display("reset mid-CALC -> rd_data=0x%016h wr_ready=%0b", rd_data, wr_ready);
      last_res = '0;
      cycle();
      reset = 1'b1;
      cycle();
      full_op(32'd5, 32'd7, 1'b0);
      check_val("after_reset_35", rd_data, 64'd35);

`ifdef MUL_SIGNED_EN
      full_op(32'hFFFFFFFE, 32'd3, 1'b0);
      check_val("signed_neg6", rd_data, 64'hFFFFFFFFFFFFFFFA);
      full_op(32'h80000000, 32'h80000000, 1'b0);
      check_val("signed_min_sq", rd_data, 64'h4000000000000000);
`endif

      // Randomized operations with random read delay and random noise
      for (int t = 0; t < 40; t++) begin
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 7))
            0: ra = 32'd0;
            1: rb = 32'hFFFFFFFF;
            2: ra = 32'h80000000;
            3: rb = 32'd1;
            default: ;
         endcase
         start_op(ra, rb);
         finish_op(model(ra, rb), 1'($urandom_range(0, 1)));
         $display("op 0x%08h * 0x%08h -> 0x%016h (expect 0x%016h)", ra, rb, rd_data, model(ra, rb));
         dly = $urandom_range(0, 3);
         for (int d = 0; d < dly; d++) begin
            cycle();
            check_val("rand_hold_data", rd_data, last_res);
         end
         read_op();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
